// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for a multicycle RV32I datapath.
// Shares one req/ready memory port between instruction and data access, counts retired instructions.
module multicycle_control #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ru_write,
    output logic [1:0]       ru_data_src,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] instret
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
    localparam logic [1:0] C_ALU = 2'd0, C_LOAD = 2'd1, C_STORE = 2'd2, C_BR = 2'd3;

    logic [2:0]       state_q, state_d;
    logic [1:0]       cls_q, cls_d, cls;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d, timeout_q, timeout_d;
    logic             legal, req, to_hit, retire;

    always_comb begin
        legal = 1'b1;
        cls   = C_ALU;
        case (opcode)
            7'b0110011, 7'b0010011: cls = C_ALU;
            7'b0000011:             cls = C_LOAD;
            7'b0100011:             cls = C_STORE;
            7'b1100011:             cls = C_BR;
            default:                legal = 1'b0;
        endcase
    end

    // A completing transfer always beats the timeout, since the counter only advances on ready-low cycles.
    assign req    = state_q == S_FETCH || state_q == S_MEM;
    assign to_hit = req && !mem_ready && wcnt_q == WW'(TIMEOUT - 1);
    assign retire = (state_q == S_WB) || (state_q == S_EXEC && cls_q == C_BR)
                 || (state_q == S_MEM && cls_q == C_STORE && mem_ready);

    assign cls_d     = state_q == S_DECODE ? cls : cls_q;
    assign wcnt_d    = req && !mem_ready ? wcnt_q + WW'(1) : '0;
    assign instret_d = instret_q + CNT_W'(retire);
    assign illegal_d = illegal_q || (state_q == S_DECODE && !legal);
    assign timeout_d = timeout_q || to_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cls_q     <= C_ALU;
            wcnt_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wcnt_q    <= wcnt_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = S_HALT;
        case (state_q)
            S_FETCH:  state_d = to_hit ? S_HALT : mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = legal ? S_EXEC : S_HALT;
            S_EXEC:   state_d = cls_q == C_BR ? S_FETCH : cls_q == C_ALU ? S_WB : S_MEM;
            S_MEM:    state_d = to_hit ? S_HALT : !mem_ready ? S_MEM
                              : cls_q == C_LOAD ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    always_comb begin
        mem_req     = !rst && req;
        mem_we      = !rst && state_q == S_MEM && cls_q == C_STORE;
        addr_src    = !rst && state_q == S_MEM;
        ir_write    = !rst && state_q == S_FETCH && mem_ready;
        pc_write    = !rst && ((state_q == S_FETCH && mem_ready)
                            || (state_q == S_EXEC && cls_q == C_BR && br_taken));
        pc_src      = !rst && state_q == S_EXEC && cls_q == C_BR;
        ru_write    = !rst && state_q == S_WB;
        ru_data_src = {1'b0, !rst && state_q == S_WB && cls_q == C_LOAD};
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign instret = instret_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multicycle sequencer with CNT_W=3, TIMEOUT=4.
module tb_multicycle_control;
    localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                           OP_BR = 7'b1100011, OP_BAD = 7'b1111111;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = OP_R;
    logic       br_taken = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, mem_we, addr_src, ir_write, pc_write, pc_src, ru_write;
    logic [1:0] ru_data_src;
    logic [2:0] state;
    logic       illegal, timeout;
    logic [2:0] instret;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(3), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .ru_write(ru_write), .ru_data_src(ru_data_src),
        .state(state), .illegal(illegal), .timeout(timeout), .instret(instret)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and apply mem_ready for the new cycle; outputs are sampled 2 time units after the edge.
    task automatic step(input logic rdy);
        @(posedge clk);
        #1 mem_ready = rdy;
        #1;
    endtask

    initial begin
        step(1);
        check("rst_state", 32'(state), 0);
        check("rst_req", 32'(mem_req), 0);
        check("rst_instret", 32'(instret), 0);
        check("rst_flags", 32'({illegal, timeout}), 0);
        rst = 1'b0;
        #1;
        check("r_fetch_req", 32'(mem_req), 1);
        check("r_fetch_irw", 32'({ir_write, pc_write, pc_src, addr_src}), 4'b1100);
        step(1); check("r_decode", 32'(state), 1);
        step(1); check("r_exec", 32'(state), 2);
        check("r_exec_ruw", 32'(ru_write), 0);
        step(1); check("r_wb", 32'(state), 4);
        check("r_wb_ruw", 32'({ru_write, ru_data_src}), 3'b100);
        step(1); check("r_back", 32'(state), 0);
        check("r_instret", 32'(instret), 1);

        opcode = OP_LD;
        step(1); step(1);
        step(0); check("ld_mem0", 32'({state, mem_req, addr_src, mem_we}), {3'd3, 3'b110});
        step(0); step(0); check("ld_mem2", 32'({state, mem_req, addr_src, mem_we}), {3'd3, 3'b110});
        step(1); check("ld_mem3", 32'({state, mem_req, addr_src, mem_we}), {3'd3, 3'b110});
        step(1); check("ld_wb", 32'({state, ru_write, ru_data_src}), {3'd4, 3'b101});
        step(1); check("ld_back", 32'(state), 0);
        check("ld_instret", 32'(instret), 2);

        opcode = OP_ST;
        step(1); step(1); check("st_exec_we", 32'({mem_req, mem_we}), 0);
        step(1); check("st_mem", 32'({state, mem_we, addr_src}), {3'd3, 2'b11});
        step(1); check("st_back", 32'({state, mem_we}), 0);
        check("st_instret", 32'(instret), 3);

        opcode = OP_BR;
        br_taken = 1'b1;
        step(1); step(1); check("bt_exec", 32'({state, pc_write, pc_src}), {3'd2, 2'b11});
        step(1); check("bt_instret", 32'({state, instret}), {3'd0, 3'd4});
        br_taken = 1'b0;
        step(1); step(1); check("bn_exec", 32'({state, pc_write, pc_src}), {3'd2, 2'b01});
        step(1); check("bn_instret", 32'({state, instret}), {3'd0, 3'd5});

        opcode = OP_R;
        repeat (8) step(1);
        check("wrap_7", 32'(instret), 7);
        repeat (4) step(1);
        check("wrap_0", 32'({state, instret}), 0);

        opcode = OP_LD;
        step(1); step(1);
        step(0); check("rm_mem_req", 32'({state, mem_req}), {3'd3, 1'b1});
        rst = 1'b1;
        #1 check("rm_req_drop", 32'({mem_req, addr_src}), 0);
        step(0); check("rm_state", 32'({state, mem_req}), 0);
        rst = 1'b0;

        #1 check("to_c1", 32'({state, mem_req, ir_write}), {3'd0, 2'b10});
        step(0); step(0);
        step(0); check("to_c4", 32'({state, mem_req, timeout}), {3'd0, 2'b10});
        step(0); check("to_halt", 32'({state, timeout, mem_req, ir_write}), {3'd5, 3'b100});
        rst = 1'b1;
        step(0); rst = 1'b0;
        #1 check("tr_c1", 32'({state, timeout}), 0);
        step(0); step(0);
        step(1); check("tr_c4_irw", 32'(ir_write), 1);
        step(1); check("tr_decode", 32'({state, timeout}), {3'd1, 1'b0});

        opcode = OP_BAD;
        #1;
        step(1); check("ill_halt", 32'({state, illegal, mem_req}), {3'd5, 2'b10});
        step(1); check("ill_stay", 32'({state, mem_req, pc_write}), {3'd5, 2'b00});
        rst = 1'b1;
        step(1); check("ill_rst", 32'({state, illegal}), 0);
        rst = 1'b0;
        #1 check("ill_rst_req", 32'(mem_req), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
